// File: rtl/ifmap_stream_feeder.sv
// ifmap_stream_feeder
// Streams a rectangular block of pixels out of a sync-read memory, row by row,
// into the PE IFMap FIFO. Each word carries start-of-row / end-of-row tags:
// {sor, eor, pixel}. A 2-entry skid buffer absorbs the one-cycle memory latency,
// and a credit check on read issue keeps the skid from ever overflowing while
// still allowing one word per cycle when the FIFO is always ready.
module ifmap_stream_feeder #(
    parameter int PIXEL_WIDTH = 16,
    parameter int IFMAP_WIDTH = 18,
    parameter int ADDR_WIDTH  = 10,
    parameter int LEN_SIZE    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0]  row_stride,
    input  logic [LEN_SIZE-1:0]    row_len,
    input  logic [LEN_SIZE-1:0]    num_rows,
    output logic                   mem_ren,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [PIXEL_WIDTH-1:0] mem_rdata,
    input  logic                   ifmap_ready,
    output logic                   ifmap_wen,
    output logic [IFMAP_WIDTH-1:0] ifmap_out,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_reg;
    logic                   busy_reg;
    logic                   done_reg;

    // Transfer configuration captured on the start cycle
    logic [ADDR_WIDTH-1:0]  row_stride_reg;
    logic [LEN_SIZE-1:0]    row_len_reg;
    logic [LEN_SIZE-1:0]    num_rows_reg;

    // Read-side walk position
    logic [ADDR_WIDTH-1:0]  row_base_reg;
    logic [LEN_SIZE-1:0]    col_reg;
    logic [LEN_SIZE-1:0]    row_reg;
    logic [ADDR_WIDTH-1:0]  last_addr_reg;

    // One outstanding read and the tags that travel with it
    logic                   inflight_reg;
    logic                   inflight_sor_reg;
    logic                   inflight_eor_reg;

    // Two-entry skid buffer (circular, pointer based)
    logic [IFMAP_WIDTH-1:0] skid_entry [2];
    logic                   skid_rd_reg;
    logic                   skid_wr_reg;
    logic [1:0]             skid_occ_reg;

    logic                   skid_nonempty;
    logic                   pop;
    logic                   push;
    logic [2:0]             credit_used;
    logic [2:0]             credit_cap;
    logic                   credit_ok;
    logic                   issue;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic                   col_is_first;
    logic                   col_is_last;
    logic                   row_is_last;
    logic                   last_issue;
    logic [IFMAP_WIDTH-1:0] push_word;
    logic                   drain_empty;

    assign skid_nonempty = (skid_occ_reg != 2'd0);
    assign pop           = skid_nonempty && ifmap_ready;
    assign push          = inflight_reg;
    assign push_word     = {inflight_sor_reg, inflight_eor_reg, mem_rdata};

    // A new read may only issue if, after this cycle's pop, the skid plus the
    // outstanding read still leave room for the data it will return.
    assign credit_used = {1'b0, skid_occ_reg} + {2'b00, inflight_reg};
    assign credit_cap  = 3'd2 + {2'b00, pop};
    assign credit_ok   = (credit_used < credit_cap);
    assign issue       = (state_reg == ST_RUN) && credit_ok;

    assign cur_addr     = row_base_reg + ADDR_WIDTH'(col_reg);
    assign col_is_first = (col_reg == '0);
    assign col_is_last  = (col_reg == row_len_reg - LEN_SIZE'(1));
    assign row_is_last  = (row_reg == num_rows_reg - LEN_SIZE'(1));
    assign last_issue   = issue && col_is_last && row_is_last;

    // Transfer is finished once the skid empties this cycle and no read is pending
    assign drain_empty = !inflight_reg &&
                         ((skid_occ_reg == 2'd0) || ((skid_occ_reg == 2'd1) && pop));

    assign mem_ren   = issue;
    assign mem_addr  = issue ? cur_addr : last_addr_reg;
    assign ifmap_wen = pop;
    assign ifmap_out = skid_nonempty ? skid_entry[skid_rd_reg] : '0;
    assign busy      = busy_reg;
    assign done      = done_reg;

    // Control FSM: config capture, row-major address walk, drain and completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            row_stride_reg   <= '0;
            row_len_reg      <= '0;
            num_rows_reg     <= '0;
            row_base_reg     <= '0;
            col_reg          <= '0;
            row_reg          <= '0;
            last_addr_reg    <= '0;
            inflight_reg     <= 1'b0;
            inflight_sor_reg <= 1'b0;
            inflight_eor_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            inflight_reg <= issue;
            if (issue) begin
                inflight_sor_reg <= col_is_first;
                inflight_eor_reg <= col_is_last;
                last_addr_reg    <= cur_addr;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        row_stride_reg <= row_stride;
                        row_len_reg    <= row_len;
                        num_rows_reg   <= num_rows;
                        row_base_reg   <= base_addr;
                        col_reg        <= '0;
                        row_reg        <= '0;
                        busy_reg       <= 1'b1;
                        if ((row_len == '0) || (num_rows == '0)) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (issue) begin
                        if (col_is_last) begin
                            col_reg      <= '0;
                            row_reg      <= row_reg + LEN_SIZE'(1);
                            row_base_reg <= row_base_reg + row_stride_reg;
                        end else begin
                            col_reg <= col_reg + LEN_SIZE'(1);
                        end
                    end
                    if (last_issue) begin
                        state_reg <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (drain_empty) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Skid pointers and occupancy; push and pop together leave occupancy unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_rd_reg  <= 1'b0;
            skid_wr_reg  <= 1'b0;
            skid_occ_reg <= 2'd0;
        end else begin
            if (push) begin
                skid_wr_reg <= ~skid_wr_reg;
            end
            if (pop) begin
                skid_rd_reg <= ~skid_rd_reg;
            end
            skid_occ_reg <= skid_occ_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // Skid storage: data needs no reset since an empty skid always reads as zero
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_skid
            always_ff @(posedge clk) begin
                if (push && (skid_wr_reg == 1'(gi))) begin
                    skid_entry[gi] <= push_word;
                end
            end
        end
    endgenerate

endmodule
